// File: rtl/ps2_wasd_receiver_pkg.sv
// rtl/ps2_wasd_receiver_pkg.sv - scan codes, frame states and direction lookup for the PS/2 WASD receiver
package ps2_wasd_receiver_pkg;

    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_A     = 8'h1C;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_D     = 8'h23;
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_RIGHT = 8'h74;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Returns a {w, a, s, d} one-hot mask, or zero for codes that are not a direction
    function automatic logic [3:0] dir_lookup(input logic [7:0] code, input logic ext);
        logic [3:0] mask;
        mask = 4'b0000;
        if (!ext) begin
            case (code)
                PS2_W:   mask = 4'b1000;
                PS2_A:   mask = 4'b0100;
                PS2_S:   mask = 4'b0010;
                PS2_D:   mask = 4'b0001;
                default: mask = 4'b0000;
            endcase
        end else begin
            case (code)
                PS2_UP:    mask = 4'b1000;
                PS2_LEFT:  mask = 4'b0100;
                PS2_DOWN:  mask = 4'b0010;
                PS2_RIGHT: mask = 4'b0001;
                default:   mask = 4'b0000;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_wasd_receiver_line_filter.sv
// rtl/ps2_wasd_receiver_line_filter.sv - PS/2 pin synchronizer, run-length clock filter and falling-edge strobe
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data,
    output logic clk_level,
    output logic strobe
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [CW-1:0] run_cnt;
    logic          level;
    logic          level_d;

    // Sync and filtered levels reset to the idle-high bus state so reset release makes no edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            run_cnt   <= '0;
            level     <= 1'b1;
            level_d   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            level_d   <= level;
            if (clk_sync[1] == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= ~level;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign data      = data_sync[1];
    assign clk_level = level;
    assign strobe    = level_d & ~level;

endmodule

// File: rtl/ps2_wasd_receiver.sv
// rtl/ps2_wasd_receiver.sv - PS/2 frame receiver and make/break decoder driving held-key w/a/s/d levels
module ps2_wasd_receiver
    import ps2_wasd_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w,
    output logic       a,
    output logic       s,
    output logic       d,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          sample_data;
    logic          filt_clk;
    logic          strobe;
    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;
    logic          brk;
    logic          ext;
    logic          timeout;
    logic [3:0]    hit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (sample_data),
        .clk_level (filt_clk),
        .strobe    (strobe)
    );

    assign timeout    = (state != ST_IDLE) && filt_clk && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign code_valid = (state == ST_DONE);

    always_comb begin
        hit = dir_lookup(scan_code, ext);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            tmo_cnt     <= '0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            scan_code   <= '0;
            frame_error <= 1'b0;
            {w, a, s, d} <= 4'b0000;
        end else begin
            frame_error <= 1'b0;
            if (state == ST_IDLE || strobe)
                tmo_cnt <= '0;
            else if (filt_clk)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (timeout) begin
                state       <= ST_IDLE;
                frame_error <= 1'b1;
                brk         <= 1'b0;
                ext         <= 1'b0;
                tmo_cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (strobe) begin
                        if (!sample_data) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    ST_DATA: if (strobe) begin
                        shift   <= {sample_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: if (strobe) begin
                        parity_bit <= sample_data;
                        state      <= ST_STOP;
                    end
                    ST_STOP: if (strobe) begin
                        if (sample_data && (^{shift, parity_bit})) begin
                            scan_code <= shift;
                            state     <= ST_DONE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        if (scan_code == PS2_EXT) begin
                            ext <= 1'b1;
                        end else if (scan_code == PS2_BREAK) begin
                            brk <= 1'b1;
                        end else if (scan_code == 8'h00 || scan_code == 8'hFF) begin
                            {w, a, s, d} <= 4'b0000;
                            brk <= 1'b0;
                            ext <= 1'b0;
                        end else begin
                            // Letter and arrow sources share an output; a break from either clears it
                            if (hit[3]) w <= ~brk;
                            if (hit[2]) a <= ~brk;
                            if (hit[1]) s <= ~brk;
                            if (hit[0]) d <= ~brk;
                            brk <= 1'b0;
                            ext <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_wasd_receiver.sv
// tb/tb_ps2_wasd_receiver.sv - self-checking bench for ps2_wasd_receiver with a key-state reference model
module tb_ps2_wasd_receiver;
    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       w, a, s, d;
    logic [7:0] scan_code;
    logic       code_valid, frame_error;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ps2_wasd_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .w           (w),
        .a           (a),
        .s           (s),
        .d           (d),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .frame_error (frame_error)
    );

    int         cv_cnt = 0;
    int         fe_cnt = 0;
    logic [3:0] dir_at_cv = 4'b0;
    logic [3:0] dir_after_cv = 4'b0;
    logic       cv_prev = 1'b0;

    always @(negedge clk) begin
        if (cv_prev) dir_after_cv = {w, a, s, d};
        if (code_valid) begin
            cv_cnt++;
            dir_at_cv = {w, a, s, d};
        end
        cv_prev = code_valid;
        if (frame_error) fe_cnt++;
    end

    // Reference model: held-key set plus pending prefix flags
    logic [7:0] let_tab [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] ext_tab [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
    logic [3:0] m_dir = 4'b0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic model_byte(input logic [7:0] b);
        m_last = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'h00 || b == 8'hFF) begin
            m_dir = 4'b0; m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if ((m_ext ? ext_tab[i] : let_tab[i]) == b) m_dir[3-i] = !m_brk;
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        cycles(HALF / 2);
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
        cycles(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        cycles(20);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 11))
            0: return 8'h1D;  1: return 8'h1C;  2: return 8'h1B;  3: return 8'h23;
            4: return 8'h75;  5: return 8'h6B;  6: return 8'h72;  7: return 8'h74;
            8: return 8'hE0;  9: return 8'hF0;
            10: return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    int         cv0, fe0, n;
    logic [7:0] rb;
    logic       bad;

    initial begin
        cycles(5);
        check("reset_dirs", {w, a, s, d}, 4'b0000);
        check("reset_scan", scan_code, 8'h00);
        check("reset_pulses", {code_valid, frame_error}, 2'b00);
        reset = 1'b1;
        cycles(20);

        cv0 = cv_cnt;
        good(8'h1D);
        check("w_make_cv", cv_cnt - cv0, 1);
        check("w_make_scan", scan_code, 8'h1D);
        check("w_during_done", dir_at_cv, 4'b0000);
        check("w_after_done", dir_after_cv, 4'b1000);
        cv0 = cv_cnt;
        good(8'hF0); good(8'h1D);
        check("w_break_cv", cv_cnt - cv0, 2);
        check("w_break_dir", {w, a, s, d}, 4'b0000);

        good(8'hE0); good(8'h6B);
        check("left_make", {w, a, s, d}, 4'b0100);
        good(8'hE0); good(8'hF0); good(8'h6B);
        check("left_break", {w, a, s, d}, 4'b0000);
        good(8'h6B);
        check("6b_no_ext", {w, a, s, d}, m_dir);

        good(8'h1D); good(8'h23);
        check("w_and_d", {w, a, s, d}, 4'b1001);
        good(8'hF0); good(8'h23);
        check("d_release", {w, a, s, d}, 4'b1000);

        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1);
        check("parity_fe", fe_cnt - fe0, 1);
        check("parity_cv", cv_cnt - cv0, 0);
        check("parity_dir", {w, a, s, d}, m_dir);
        good(8'h1C);
        check("after_parity", {w, a, s, d}, m_dir);
        check("after_parity_scan", scan_code, 8'h1C);

        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        n = 0;
        while (fe_cnt == fe0 && n < TO + 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("timeout_fe", fe_cnt - fe0, 1);
        check("timeout_window", (n >= TO - 20 && n <= TO + 20) ? 1 : 0, 1);
        good(8'h1B);
        check("after_timeout", {w, a, s, d}, m_dir);
        check("after_timeout_s", s, 1'b1);

        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(40);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_cv", cv_cnt - cv0, 0);

        good(8'h1D);
        check("pre_reset_w", w, 1'b1);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("reset_async_dirs", {w, a, s, d}, 4'b0000);
        m_dir = 4'b0; m_brk = 1'b0; m_ext = 1'b0; m_last = 8'h00;
        cycles(2);
        reset = 1'b1;
        cycles(20);
        good(8'h1C);
        check("post_reset_decode", {w, a, s, d}, 4'b0100);

        for (int k = 0; k < 40; k++) begin
            rb  = pick_byte();
            bad = ($urandom_range(0, 7) == 0);
            cv0 = cv_cnt; fe0 = fe_cnt;
            send_frame(rb, bad);
            if (!bad) model_byte(rb);
            check("rand_dir", {w, a, s, d}, m_dir);
            check("rand_cv", cv_cnt - cv0, bad ? 0 : 1);
            check("rand_fe", fe_cnt - fe0, bad ? 1 : 0);
            check("rand_scan", scan_code, m_last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
